// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the column configuration writer: FSM encoding, header
// field positions and the CRC-16-CCITT word update used by the optional trailer check.
package frame_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_CRC    = 2'd2,
        ST_STROBE = 2'd3
    } state_t;

    localparam int HDR_MARK_BIT = 31;
    localparam int HDR_IDX_MSB  = 15;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // MSB-first update over all 32 bits of one word.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] word);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC16_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_strobe_gen.sv
// Issues the one-hot FrameStrobe for a frame index and holds it for StrobeCycles
// cycles; done is high during the final strobe cycle.
module frame_strobe_gen
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int StrobeCycles    = 2
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [HDR_IDX_MSB:0]       idx,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       done
);

    localparam int CNT_W = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

    logic [CNT_W-1:0]           r_cnt;
    logic [MaxFramesPerCol-1:0] r_strobe;
    logic [MaxFramesPerCol-1:0] w_onehot;
    logic                       w_active;

    // The index is held in decoded form: the strobe register itself.
    for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_dec
        assign w_onehot[gi] = (idx == (HDR_IDX_MSB + 1)'(gi));
    end

    assign w_active    = |r_strobe;
    assign done        = w_active && (r_cnt == '0);
    assign FrameStrobe = r_strobe;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_strobe <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_strobe <= w_onehot;
            r_cnt    <= CNT_W'(StrobeCycles - 1);
        end else if (done) begin
            r_strobe <= '0;
        end else if (w_active) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/frame_config_writer.sv
// Column configuration source: header + NumberOfRows data words -> FrameData rows
// and a one-hot FrameStrobe. Define FRAME_WRITER_CRC_EN to require a CRC-16 trailer word.
module frame_config_writer
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfRows    = 4,
    parameter int StrobeCycles    = 2
) (
    input  logic                                    CLK,
    input  logic                                    resetn,
    input  logic [31:0]                             cfg_data,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]              FrameStrobe,
    output logic                                    busy,
    output logic                                    frame_err,
    output logic [15:0]                             frame_count
);

    localparam int ROW_W = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

    state_t               r_state;
    logic [ROW_W-1:0]     r_row;
    logic [HDR_IDX_MSB:0] r_idx;
    logic                 r_drop;
    logic                 r_err;
    logic [15:0]          r_count;

    logic                 w_accept;
    logic                 w_last_row;
    logic                 w_start;
    logic                 w_done;
    logic [HDR_IDX_MSB:0] w_hdr_idx;
    logic                 w_hdr_drop;

    assign cfg_ready   = (r_state != ST_STROBE);
    assign busy        = (r_state != ST_IDLE);
    assign frame_err   = r_err;
    assign frame_count = r_count;

    assign w_accept   = cfg_valid && cfg_ready;
    assign w_last_row = (r_row == ROW_W'(NumberOfRows - 1));
    assign w_hdr_idx  = cfg_data[HDR_IDX_MSB:0];
    assign w_hdr_drop = (w_hdr_idx >= (HDR_IDX_MSB + 1)'(MaxFramesPerCol));

`ifdef FRAME_WRITER_CRC_EN
    logic [15:0] r_crc;
    logic        w_crc_ok;

    assign w_crc_ok = (cfg_data[15:0] == r_crc);
    assign w_start  = w_accept && (r_state == ST_CRC) && w_crc_ok && !r_drop;

    // Header excluded: the running CRC restarts on every header.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_crc <= CRC16_INIT;
        end else if (w_accept && r_state == ST_IDLE) begin
            r_crc <= CRC16_INIT;
        end else if (w_accept && r_state == ST_DATA) begin
            r_crc <= crc16_word(r_crc, cfg_data);
        end
    end
`else
    assign w_start = w_accept && (r_state == ST_DATA) && w_last_row && !r_drop;
`endif

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_idx   <= '0;
            r_drop  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && cfg_data[HDR_MARK_BIT]) begin
                        r_idx   <= w_hdr_idx;
                        r_drop  <= w_hdr_drop;
                        r_row   <= '0;
                        r_state <= ST_DATA;
                        if (w_hdr_drop) r_err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        if (w_last_row) begin
                            r_row <= '0;
`ifdef FRAME_WRITER_CRC_EN
                            r_state <= ST_CRC;
`else
                            r_state <= r_drop ? ST_IDLE : ST_STROBE;
`endif
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
`ifdef FRAME_WRITER_CRC_EN
                ST_CRC: begin
                    if (w_accept) begin
                        if (w_crc_ok) begin
                            r_state <= r_drop ? ST_IDLE : ST_STROBE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_STROBE: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Dropped frames still land in FrameData; rows are only ever overwritten.
    for (genvar gi = 0; gi < NumberOfRows; gi++) begin : g_row
        logic [FrameBitsPerRow-1:0] r_row_data;

        always_ff @(posedge CLK or negedge resetn) begin
            if (!resetn) begin
                r_row_data <= '0;
            end else if (w_accept && r_state == ST_DATA && r_row == ROW_W'(gi)) begin
                r_row_data <= cfg_data[FrameBitsPerRow-1:0];
            end
        end

        assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = r_row_data;
    end

    frame_strobe_gen #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .StrobeCycles    (StrobeCycles)
    ) u_strobe (
        .CLK         (CLK),
        .resetn      (resetn),
        .start       (w_start),
        .idx         (r_idx),
        .FrameStrobe (FrameStrobe),
        .done        (w_done)
    );

endmodule

// File: tb/tb_frame_config_writer.sv
// Scoreboard bench for frame_config_writer: stimulus pushes expected strobes,
// a negedge monitor pops and checks them as the DUT presents FrameStrobe.
module tb_frame_config_writer;

    localparam int MAXF  = 20;
    localparam int FBR   = 32;
    localparam int NROWS = 4;
    localparam int SC    = 2;

    logic              CLK = 1'b0;
    logic              resetn = 1'b0;
    logic [31:0]       cfg_data = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [127:0]      FrameData;
    logic [MAXF-1:0]   FrameStrobe;
    logic              busy;
    logic              frame_err;
    logic [15:0]       frame_count;

    frame_config_writer #(
        .MaxFramesPerCol (MAXF),
        .FrameBitsPerRow (FBR),
        .NumberOfRows    (NROWS),
        .StrobeCycles    (SC)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [19:0]  strobe;
        logic [127:0] data;
        logic [15:0]  count;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference CRC over the four data words, row 0 first.
    function automatic logic [15:0] ref_crc(input logic [127:0] data);
        logic [15:0] c;
        logic        top;
        c = 16'hFFFF;
        for (int r = 0; r < 4; r++) begin
            for (int b = 31; b >= 0; b--) begin
                top = c[15];
                c   = c << 1;
                if (top ^ data[r*32 + b]) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // Monitor: one scoreboard entry per strobe pulse.
    int   mon_hi   = 0;
    bit   mon_live = 0;
    exp_t mon_cur;

    always @(negedge CLK) begin
        if (!resetn) begin
            mon_hi   = 0;
            mon_live = 0;
        end else if (FrameStrobe != '0) begin
            if (mon_hi == 0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_strobe: got %05h expected none", FrameStrobe);
                    mon_live = 0;
                end else begin
                    mon_cur  = sb.pop_front();
                    mon_live = 1;
                    check("strobe_value", FrameStrobe, mon_cur.strobe);
                    check("frame_data", FrameData, mon_cur.data);
                end
            end else if (mon_live) begin
                check("strobe_hold", FrameStrobe, mon_cur.strobe);
            end
            if (mon_live) check("ready_low_in_strobe", cfg_ready, 1'b0);
            mon_hi++;
        end else if (mon_hi != 0) begin
            if (mon_live) begin
                check("strobe_width", mon_hi, SC);
                check("frame_count", frame_count, mon_cur.count);
                check("ready_after_strobe", cfg_ready, 1'b1);
                $display("strobe %05h data %032h count %0d", mon_cur.strobe, mon_cur.data, frame_count);
            end
            mon_hi   = 0;
            mon_live = 0;
        end
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic send_word(input logic [31:0] w);
        int guard;
        guard     = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        while (!cfg_ready && guard < 50) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 1'b0, 1'b1);
        @(posedge CLK); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge CLK); #1;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [127:0] data,
                              input bit gap, input logic [15:0] crc_xor);
        send_word(hdr);
        if (gap) idle_cycle();
        for (int r = 0; r < 4; r++) begin
            send_word(data[r*32 +: 32]);
            if (gap && r < 3) idle_cycle();
        end
`ifdef FRAME_WRITER_CRC_EN
        if (gap) idle_cycle();
        send_word({16'h0000, ref_crc(data) ^ crc_xor});
`endif
        $display("frame hdr %08h sent gap=%0d", hdr, gap);
    endtask

    task automatic push_exp(input logic [19:0] s, input logic [127:0] d, input logic [15:0] c);
        exp_t e;
        e.strobe = s;
        e.data   = d;
        e.count  = c;
        sb.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_strobe"}, FrameStrobe, 20'h0);
        check({tag, "_data"}, FrameData, 128'h0);
        check({tag, "_err"}, frame_err, 1'b0);
        check({tag, "_count"}, frame_count, 16'h0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_state("reset");
        check("reset_ready", cfg_ready, 1'b1);
        #2 resetn = 1'b1;
        @(posedge CLK); #1;

        // Basic frame, idx 5.
        push_exp(20'h00020, 128'h44444444_33333333_22222222_11111111, 16'd1);
        send_frame(32'h8000_0005, 128'h44444444_33333333_22222222_11111111, 0, 16'h0);
        repeat (4) idle_cycle();

        // Padding words, then idx 19.
        for (int i = 0; i < 3; i++) send_word(32'h0000_0000);
        check("busy_after_padding", busy, 1'b0);
        push_exp(20'h80000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'd2);
        send_frame(32'h8000_0013, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 16'h0);
        repeat (4) idle_cycle();
        check("err_after_padding", frame_err, 1'b0);

        // Out-of-range index 20: consumed, written, not strobed.
        send_frame(32'h8000_0014, 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001, 0, 16'h0);
        repeat (4) idle_cycle();
        check("err_on_bad_idx", frame_err, 1'b1);
        check("count_on_bad_idx", frame_count, 16'd2);
        check("data_on_bad_idx", FrameData, 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001);
        push_exp(20'h00001, 128'h0F0F0F0F_F0F0F0F0_12345678_87654321, 16'd3);
        send_frame(32'h8000_0000, 128'h0F0F0F0F_F0F0F0F0_12345678_87654321, 0, 16'h0);
        repeat (4) idle_cycle();
        check("err_sticky", frame_err, 1'b1);

        // cfg_valid toggling, two consecutive frames.
        push_exp(20'h00080, 128'h44444444_33333333_22222222_11111111, 16'd4);
        send_frame(32'h8000_0007, 128'h44444444_33333333_22222222_11111111, 1, 16'h0);
        push_exp(20'h00100, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 16'd5);
        send_frame(32'h8000_0008, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 1, 16'h0);
        repeat (4) idle_cycle();
        check("count_after_toggle", frame_count, 16'd5);

        // Reset during the first strobe cycle (no scoreboard entry: pulse is cut short).
        send_frame(32'h8000_0003, 128'h55555555_66666666_77777777_88888888, 0, 16'h0);
        check("strobe_before_reset", FrameStrobe, 20'h00008);
        check("busy_before_reset", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check_reset_state("midstrobe_reset");
        check("midstrobe_reset_ready", cfg_ready, 1'b1);
        repeat (2) @(posedge CLK);
        #2 resetn = 1'b1;
        @(posedge CLK); #1;
        push_exp(20'h00200, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 16'd1);
        send_frame(32'h8000_0009, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 0, 16'h0);
        repeat (4) idle_cycle();
        check("err_after_reset", frame_err, 1'b0);

`ifdef FRAME_WRITER_CRC_EN
        push_exp(20'h00010, 128'h01020304_05060708_090A0B0C_0D0E0F10, 16'd2);
        send_frame(32'h8000_0004, 128'h01020304_05060708_090A0B0C_0D0E0F10, 0, 16'h0);
        repeat (4) idle_cycle();
        check("crc_good_err", frame_err, 1'b0);
        send_frame(32'h8000_0004, 128'h01020304_05060708_090A0B0C_0D0E0F10, 0, 16'h0001);
        repeat (4) idle_cycle();
        check("crc_bad_err", frame_err, 1'b1);
        check("crc_bad_count", frame_count, 16'd2);
`endif

        repeat (8) idle_cycle();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
